// File: rtl/ps2_keyboard_rx.sv
// PS/2 keyboard receiver: synchronizes and filters the PS/2 lines, then decodes frames into make codes.
// When REPEAT_FILTER_EN is defined, repeated make codes are suppressed until a break sequence completes.
module ps2_keyboard_rx #(
    parameter int SYNC_STAGES    = 2,
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 100000,
    parameter int READY_CYCLES   = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] keyboard_data,
    output logic       keyboard_ready,
    output logic       extended,
    output logic       frame_err
);
    localparam int FLT_W = $clog2(FILTER_LEN + 1);
    localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);
    localparam int RDY_W = $clog2(READY_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, RECV, CHECK, DECODE} state_t;

    logic [SYNC_STAGES-1:0] clk_sync;
    logic [SYNC_STAGES-1:0] data_sync;
    logic                   clk_s;
    logic                   bit_in;
    logic                   clk_filt;
    logic [FLT_W-1:0]       flt_cnt;
    logic                   flt_done;
    logic                   fall;

    state_t                 state;
    state_t                 state_d;
    logic [3:0]             bit_cnt;
    logic [TO_W-1:0]        to_cnt;
    logic [7:0]             shift;
    logic                   parity_bit;
    logic                   stop_bit;
    logic                   frame_good;
    logic                   to_expire;
    logic                   check_fail;
    logic                   ext_pend;
    logic                   brk_pend;

    logic                   make_dec;
    logic                   suppress;
    logic                   report_req;
    logic [RDY_W-1:0]       rdy_cnt;
    logic                   pend;
    logic [7:0]             pend_data;
    logic                   pend_ext;

    // Input synchronizers
    always_ff @(posedge clk) begin
        if (rst) begin
            clk_sync  <= '1;
            data_sync <= '1;
        end else begin
            clk_sync  <= {clk_sync[SYNC_STAGES-2:0], ps2_clk};
            data_sync <= {data_sync[SYNC_STAGES-2:0], ps2_data};
        end
    end

    assign clk_s  = clk_sync[SYNC_STAGES-1];
    assign bit_in = data_sync[SYNC_STAGES-1];

    // Glitch filter: the synchronized clock must differ from the filtered one for FILTER_LEN cycles
    assign flt_done = (clk_s != clk_filt) && (flt_cnt == FLT_W'(FILTER_LEN - 1));
    assign fall     = flt_done && clk_filt;

    always_ff @(posedge clk) begin
        if (rst) begin
            clk_filt <= 1'b1;
            flt_cnt  <= '0;
        end else if (clk_s == clk_filt) begin
            flt_cnt  <= '0;
        end else if (flt_done) begin
            clk_filt <= clk_s;
            flt_cnt  <= '0;
        end else begin
            flt_cnt  <= flt_cnt + FLT_W'(1);
        end
    end

    // Frame state machine
    assign frame_good = (^shift ^ parity_bit) && stop_bit;

    always_comb begin
        state_d    = state;
        to_expire  = 1'b0;
        check_fail = 1'b0;
        case (state)
            IDLE: begin
                if (fall && !bit_in) begin
                    state_d = RECV;
                end
            end
            RECV: begin
                if (fall && bit_cnt == 4'd10) begin
                    state_d = CHECK;
                end else if (!fall && to_cnt == TO_W'(TIMEOUT_CYCLES - 1)) begin
                    state_d   = IDLE;
                    to_expire = 1'b1;
                end
            end
            CHECK: begin
                if (frame_good) begin
                    state_d = DECODE;
                end else begin
                    state_d    = IDLE;
                    check_fail = 1'b1;
                end
            end
            DECODE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            bit_cnt   <= 4'd0;
            to_cnt    <= '0;
            ext_pend  <= 1'b0;
            brk_pend  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            state     <= state_d;
            frame_err <= to_expire | check_fail;
            case (state)
                IDLE: begin
                    if (fall && !bit_in) begin
                        bit_cnt <= 4'd1;
                        to_cnt  <= '0;
                    end
                end
                RECV: begin
                    if (fall) begin
                        to_cnt <= '0;
                        if (bit_cnt != 4'd10) begin
                            bit_cnt <= bit_cnt + 4'd1;
                        end
                    end else begin
                        to_cnt <= to_cnt + TO_W'(1);
                    end
                end
                CHECK: begin
                    if (!frame_good) begin
                        ext_pend <= 1'b0;
                        brk_pend <= 1'b0;
                    end
                end
                DECODE: begin
                    if (shift == 8'hE0) begin
                        ext_pend <= 1'b1;
                    end else if (shift == 8'hF0) begin
                        brk_pend <= 1'b1;
                    end else begin
                        ext_pend <= 1'b0;
                        brk_pend <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    // Frame payload; a partial frame is simply overwritten by the next one
    always_ff @(posedge clk) begin
        if (state == RECV && fall) begin
            if (bit_cnt <= 4'd8) begin
                shift <= {bit_in, shift[7:1]};
            end else if (bit_cnt == 4'd9) begin
                parity_bit <= bit_in;
            end else begin
                stop_bit <= bit_in;
            end
        end
    end

    assign make_dec = (state == DECODE) && (shift != 8'hE0) && (shift != 8'hF0);

`ifdef REPEAT_FILTER_EN
    logic [8:0] last_make;
    logic       rpt_valid;

    assign suppress = rpt_valid && (last_make == {ext_pend, shift});

    always_ff @(posedge clk) begin
        if (rst) begin
            rpt_valid <= 1'b0;
        end else if (make_dec && brk_pend) begin
            rpt_valid <= 1'b0;
        end else if (report_req) begin
            rpt_valid <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (report_req) begin
            last_make <= {ext_pend, shift};
        end
    end
`else
    assign suppress = 1'b0;
`endif

    assign report_req = make_dec && !brk_pend && !suppress;

    // Report stage: a report arriving during an active pulse drops ready for one cycle first
    always_ff @(posedge clk) begin
        if (rst) begin
            keyboard_data  <= 8'h00;
            extended       <= 1'b0;
            keyboard_ready <= 1'b0;
            rdy_cnt        <= '0;
            pend           <= 1'b0;
        end else if (report_req && keyboard_ready) begin
            keyboard_ready <= 1'b0;
            pend           <= 1'b1;
        end else if (report_req || pend) begin
            keyboard_data  <= pend ? pend_data : shift;
            extended       <= pend ? pend_ext : ext_pend;
            keyboard_ready <= 1'b1;
            rdy_cnt        <= RDY_W'(READY_CYCLES - 1);
            pend           <= 1'b0;
        end else if (keyboard_ready) begin
            if (rdy_cnt == '0) begin
                keyboard_ready <= 1'b0;
            end else begin
                rdy_cnt <= rdy_cnt - RDY_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (report_req && keyboard_ready) begin
            pend_data <= shift;
            pend_ext  <= ext_pend;
        end
    end

endmodule
